flt2fix_engine: RTL

Hardware sequencer for the float16 to signed 8.8 fixed-point conversion the core's test program performs in software. On Start it arbitrates for the shared byte-wide data-memory port and reads the half-float from SRC_ADDR/SRC_ADDR+1. It converts the value with an iterative one-bit-per-cycle shifter, writes the result to DST_ADDR/DST_ADDR+1, and raises Done. It sits beside the core and shares data memory through an external request/grant arbiter.

---
 rtl/flt2fix_if.sv | 45 ++++
 rtl/flt2fix_engine.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/flt2fix_if.sv
`default_nettype none
// ============================================================================
//  Module      : flt2fix_if
//  Description : Control handshake and byte-wide data-memory bus between
//                the float16 -> 8.8 fixed-point engine and its environment
//                (core control, request/grant arbiter and data memory).
//  Revision    : 1.0 - initial release
// ============================================================================
interface flt2fix_if #(
    parameter int AW = 8
);
    logic          Start;      // begin conversion
    logic          Done;       // conversion finished, result in memory
    logic          mem_req;    // engine requests the memory port
    logic          mem_gnt;    // arbiter grant
    logic [AW-1:0] mem_addr;   // byte address
    logic          mem_we;     // write enable (only meaningful with grant)
    logic [7:0]    mem_wdata;  // write byte
    logic [7:0]    mem_rdata;  // read byte, one cycle after an accepted read

    // Engine side
    modport master (
        input  Start,
        input  mem_gnt,
        input  mem_rdata,
        output Done,
        output mem_req,
        output mem_addr,
        output mem_we,
        output mem_wdata
    );

    // Environment side (core, arbiter, memory)
    modport slave (
        output Start,
        output mem_gnt,
        output mem_rdata,
        input  Done,
        input  mem_req,
        input  mem_addr,
        input  mem_we,
        input  mem_wdata
    );
endinterface
`default_nettype wire

// File: rtl/flt2fix_engine.sv
`default_nettype none
// ============================================================================
//  Module      : flt2fix_engine
//  Description : Reads a float16 from data memory through a shared,
//                arbitrated byte port, converts it to signed 8.8 fixed point
//                with a one-bit-per-cycle shifter (truncating toward zero,
//                saturating on overflow) and writes the result back.
//  Revision    : 1.0 - initial release
// ============================================================================
module flt2fix_engine #(
    parameter int AW       = 8,
    parameter int SRC_ADDR = 4,
    parameter int DST_ADDR = 6
) (
    input  logic        Clk,
    input  logic        Reset,
    flt2fix_if.master   bus
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam logic [AW-1:0] c_src_lo = AW'(SRC_ADDR);
    localparam logic [AW-1:0] c_src_hi = AW'(SRC_ADDR + 1);
    localparam logic [AW-1:0] c_dst_lo = AW'(DST_ADDR);
    localparam logic [AW-1:0] c_dst_hi = AW'(DST_ADDR + 1);

    // Exponent at which the 11-bit magnitude already sits in 8.8 alignment
    localparam logic [4:0] c_exp_unity = 5'd17;
    // Exponent from which any value overflows the 8.8 range
    localparam logic [4:0] c_exp_sat   = 5'd23;
    // Right shifts beyond this always produce zero, so they are capped
    localparam logic [4:0] c_max_rshift = 5'd12;

    localparam logic [3:0] c_st_idle    = 4'd0;
    localparam logic [3:0] c_st_rd_lo   = 4'd1;
    localparam logic [3:0] c_st_rd_hi   = 4'd2;
    localparam logic [3:0] c_st_rd_wait = 4'd3;
    localparam logic [3:0] c_st_calc    = 4'd4;
    localparam logic [3:0] c_st_shift   = 4'd5;
    localparam logic [3:0] c_st_wr_lo   = 4'd6;
    localparam logic [3:0] c_st_wr_hi   = 4'd7;
    localparam logic [3:0] c_st_done    = 4'd8;

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    logic [3:0]  r_state;
    logic        r_first_hi;   // first cycle in RD_HI: low byte is on rdata
    logic [7:0]  r_f_lo;       // captured low byte of the half-float
    logic [15:0] r_f_word;     // complete half-float
    logic        r_sign;
    logic [16:0] r_mag;        // magnitude being aligned to 8.8
    logic        r_left;       // shift direction: 1 = left
    logic [3:0]  r_cnt;        // remaining shift steps
    logic [15:0] r_result;     // final 8.8 word

    // ------------------------------------------------------------------
    // Decode of the captured half-float
    // ------------------------------------------------------------------
    logic [4:0]  w_exp;
    logic [16:0] w_mag_init;
    logic        w_sat;
    logic        w_left;
    logic [3:0]  w_shift_n;
    logic [16:0] w_mag_next;

    assign w_exp      = r_f_word[14:10];
    assign w_mag_init = {6'd0, (w_exp != 5'd0), r_f_word[9:0]};
    assign w_sat      = (w_exp >= c_exp_sat);
    assign w_mag_next = r_left ? {r_mag[15:0], 1'b0} : {1'b0, r_mag[16:1]};

    // Shift direction and count from the exponent distance to unity
    always_comb begin
        w_left    = 1'b0;
        w_shift_n = 4'd0;
        if (w_exp > c_exp_unity) begin
            w_left    = 1'b1;
            w_shift_n = 4'(w_exp - c_exp_unity);
        end else if (w_exp < c_exp_unity) begin
            if ((c_exp_unity - w_exp) > c_max_rshift) begin
                w_shift_n = 4'(c_max_rshift);
            end else begin
                w_shift_n = 4'(c_exp_unity - w_exp);
            end
        end
    end

    // Saturate the aligned magnitude and apply the sign. A negative zero
    // naturally comes out as 0x0000 because -0 == 0 in two's complement.
    function automatic logic [15:0] form_result(input logic neg,
                                                input logic [16:0] m);
        logic [15:0] r;
        if (m >= 17'd32768) begin
            r = neg ? 16'h8000 : 16'h7FFF;
        end else if (neg) begin
            r = (~m[15:0]) + 16'd1;
        end else begin
            r = m[15:0];
        end
        return r;
    endfunction

    // ------------------------------------------------------------------
    // Sequencer: memory reads, decode, iterative shift, memory writes
    // ------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state    <= c_st_idle;
            r_first_hi <= 1'b0;
            r_f_lo     <= 8'd0;
            r_f_word   <= 16'd0;
            r_sign     <= 1'b0;
            r_mag      <= 17'd0;
            r_left     <= 1'b0;
            r_cnt      <= 4'd0;
            r_result   <= 16'd0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (bus.Start) begin
                        r_state <= c_st_rd_lo;
                    end
                end

                c_st_rd_lo: begin
                    if (bus.mem_gnt) begin
                        r_state    <= c_st_rd_hi;
                        r_first_hi <= 1'b1;
                    end
                end

                // The low byte answers the read accepted in RD_LO, so it is
                // valid only in the first RD_HI cycle, grant or not.
                c_st_rd_hi: begin
                    if (r_first_hi) begin
                        r_f_lo     <= bus.mem_rdata;
                        r_first_hi <= 1'b0;
                    end
                    if (bus.mem_gnt) begin
                        r_state <= c_st_rd_wait;
                    end
                end

                c_st_rd_wait: begin
                    r_f_word <= {bus.mem_rdata, r_f_lo};
                    r_state  <= c_st_calc;
                end

                c_st_calc: begin
                    r_sign <= r_f_word[15];
                    r_mag  <= w_mag_init;
                    r_left <= w_left;
                    r_cnt  <= w_shift_n;
                    if (w_sat) begin
                        r_result <= r_f_word[15] ? 16'h8000 : 16'h7FFF;
                        r_state  <= c_st_wr_lo;
                    end else if (w_shift_n == 4'd0) begin
                        r_result <= form_result(r_f_word[15], w_mag_init);
                        r_state  <= c_st_wr_lo;
                    end else begin
                        r_state  <= c_st_shift;
                    end
                end

                // One bit per cycle; the result is formed from the value
                // produced by the final step.
                c_st_shift: begin
                    r_mag <= w_mag_next;
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt == 4'd1) begin
                        r_result <= form_result(r_sign, w_mag_next);
                        r_state  <= c_st_wr_lo;
                    end
                end

                c_st_wr_lo: begin
                    if (bus.mem_gnt) begin
                        r_state <= c_st_wr_hi;
                    end
                end

                c_st_wr_hi: begin
                    if (bus.mem_gnt) begin
                        r_state <= c_st_done;
                    end
                end

                c_st_done: begin
                    if (bus.Start) begin
                        r_state <= c_st_rd_lo;
                    end
                end

                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Bus outputs decoded from the current state; writes are qualified
    // by the grant so an un-granted cycle never strobes the memory.
    // ------------------------------------------------------------------
    logic          w_req;
    logic [AW-1:0] w_addr;
    logic          w_we;
    logic [7:0]    w_wdata;
    logic          w_done;

    // Per-state drive of request, address, write strobe/data and Done
    always_comb begin
        w_req   = 1'b0;
        w_addr  = '0;
        w_we    = 1'b0;
        w_wdata = 8'd0;
        w_done  = 1'b0;
        case (r_state)
            c_st_rd_lo: begin
                w_req  = 1'b1;
                w_addr = c_src_lo;
            end
            c_st_rd_hi: begin
                w_req  = 1'b1;
                w_addr = c_src_hi;
            end
            c_st_rd_wait: begin
                w_req  = 1'b1;
                w_addr = c_src_hi;
            end
            c_st_wr_lo: begin
                w_req   = 1'b1;
                w_addr  = c_dst_lo;
                w_wdata = r_result[7:0];
                w_we    = bus.mem_gnt;
            end
            c_st_wr_hi: begin
                w_req   = 1'b1;
                w_addr  = c_dst_hi;
                w_wdata = r_result[15:8];
                w_we    = bus.mem_gnt;
            end
            c_st_done: begin
                w_done = 1'b1;
            end
            default: begin
                w_req = 1'b0;
            end
        endcase
    end

    assign bus.mem_req   = w_req;
    assign bus.mem_addr  = w_addr;
    assign bus.mem_we    = w_we;
    assign bus.mem_wdata = w_wdata;
    assign bus.Done      = w_done;

endmodule
`default_nettype wire
